rv32i_muldiv_unit: RTL



---
 rtl/rv32i_muldiv_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rv32i_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per iteration.
module rv32i_muldiv_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [WIDTH-1:0]     i_rs1_data,
    input  logic [WIDTH-1:0]     i_rs2_data,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_result_ready,
    output logic [WIDTH-1:0]     o_result,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_busy
);

    localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned SUM_W = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned PRD_W = 2 * WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_nxt;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q;
    logic [PRD_W-1:0]   prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept_c, special_c, rs1_signed_c, rs2_signed_c, s1_c, s2_c, neg_c;
    logic               div_zero_c, div_ovf_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c, special_res_c;

    // Operand decode at accept: signedness, magnitudes, result sign, special cases
    always_comb begin
        accept_c     = i_valid && (state_q == S_IDLE) && !i_flush;
        rs1_signed_c = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
        rs2_signed_c = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        s1_c         = rs1_signed_c && i_rs1_data[WIDTH-1];
        s2_c         = rs2_signed_c && i_rs2_data[WIDTH-1];
        a_mag_c      = s1_c ? (WIDTH'(0) - i_rs1_data) : i_rs1_data;
        b_mag_c      = s2_c ? (WIDTH'(0) - i_rs2_data) : i_rs2_data;
        case (i_op)
            OP_MULH, OP_DIV:   neg_c = s1_c ^ s2_c;
            OP_MULHSU, OP_REM: neg_c = s1_c;
            default:           neg_c = 1'b0;
        endcase
        div_zero_c    = (i_rs2_data == '0);
        div_ovf_c     = ((i_op == OP_DIV) || (i_op == OP_REM))
                        && (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
                        && (&i_rs2_data);
        special_c     = i_op[2] && (div_zero_c || div_ovf_c);
        if (div_zero_c) special_res_c = i_op[1] ? i_rs1_data : '1;
        else            special_res_c = i_op[1] ? '0 : i_rs1_data;
    end

    logic [SUM_W-1:0] hi_sum_c;
    logic [PRD_W-1:0] mul_nxt_c;
    logic [WIDTH:0]   sh_c, diff_c;
    logic [WIDTH-1:0] q_c, r_c;

    // One CALC iteration: BITS_PER_CYCLE multiplier digits or quotient bits
    always_comb begin
        hi_sum_c  = SUM_W'(prod_q[PRD_W-1:WIDTH])
                  + SUM_W'(a_mag_q) * SUM_W'(prod_q[BITS_PER_CYCLE-1:0]);
        mul_nxt_c = {hi_sum_c, prod_q[WIDTH-1:BITS_PER_CYCLE]};
        q_c       = prod_q[WIDTH-1:0];
        r_c       = rem_q;
        sh_c      = '0;
        diff_c    = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            sh_c   = {r_c, q_c[WIDTH-1]};
            diff_c = sh_c - {1'b0, b_mag_q};
            r_c    = diff_c[WIDTH] ? sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
            q_c    = {q_c[WIDTH-2:0], ~diff_c[WIDTH]};
        end
    end

    logic [PRD_W-1:0] prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c, fix_res_c;

    // Sign correction and result selection
    always_comb begin
        prod_fix_c = neg_q ? (PRD_W'(0) - prod_q) : prod_q;
        quo_fix_c  = neg_q ? (WIDTH'(0) - prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
        rem_fix_c  = neg_q ? (WIDTH'(0) - rem_q) : rem_q;
        case (op_q)
            OP_MUL:                        fix_res_c = prod_fix_c[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_c = prod_fix_c[PRD_W-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_res_c = quo_fix_c;
            default:                       fix_res_c = rem_fix_c;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    // Next-state logic; flush dominates everything
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (accept_c) state_nxt = special_c ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(ITER - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (i_result_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush) state_nxt = S_IDLE;
    end

    // Handshake status outputs
    always_comb begin
        o_ready = (state_q == S_IDLE);
        o_busy  = (state_q != S_IDLE);
    end

    // Datapath and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else begin
            o_valid <= (state_nxt == S_DONE);
            case (state_q)
                S_IDLE: if (accept_c) begin
                    op_q    <= i_op;
                    o_tag   <= i_tag;
                    neg_q   <= neg_c;
                    a_mag_q <= a_mag_c;
                    b_mag_q <= b_mag_c;
                    prod_q  <= {WIDTH'(0), (i_op[2] ? a_mag_c : b_mag_c)};
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    if (special_c) o_result <= special_res_c;
                end
                S_CALC: begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    prod_q <= op_q[2] ? {prod_q[PRD_W-1:WIDTH], q_c} : mul_nxt_c;
                    rem_q  <= r_c;
                end
                S_FIX:   o_result <= fix_res_c;
                default: ;
            endcase
        end
    end

endmodule
